// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port numbering, allocator states and
// the default downstream buffer depth.
package noc_pkg;

  localparam int N_PORTS = 5;
  localparam int CREDITS = 4;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/output_port_allocator_if.sv
// Request/grant/credit bundle between the router inputs and one output
// port allocator. The master side presents flits and credits; the slave
// side is the allocator itself.
interface output_port_allocator_if #(
  parameter int N_PORTS = 5,
  parameter int CW      = 3
);

  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] head;
  logic [N_PORTS-1:0] tail;
  logic               credit_in;
  logic [N_PORTS-1:0] gnt;
  logic               fire;
  logic               locked;
  logic [CW-1:0]      credits;
  logic               err;

  modport master (
    output req, head, tail, credit_in,
    input  gnt, fire, locked, credits, err
  );

  modport slave (
    input  req, head, tail, credit_in,
    output gnt, fire, locked, credits, err
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker. Requests strictly above the pointer
// win first; if there are none, the lowest request overall wins, which
// gives the wrap-around without a rotator.
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] src;

  // Two lowest-set-bit priority encoders, masked one preferred
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i > int'(ptr_i));
    end
    masked = req_i & mask;
    src    = (|masked) ? masked : req_i;
    gnt_o  = src & (~src + N'(1));
    idx_o  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_o[i]) idx_o = PW'(i);
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin head arbitration, wormhole
// lock from head to tail, and a downstream credit counter with a sticky
// overflow flag.
module output_port_allocator #(
  parameter int N_PORTS = noc_pkg::N_PORTS,
  parameter int CREDITS = noc_pkg::CREDITS,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  output_port_allocator_if.slave   bus
);

  import noc_pkg::*;

  localparam int            PW   = $clog2(N_PORTS);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  alloc_state_e       state_q, state_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      credits_q, credits_d;
  logic               err_q, err_d;
  logic [N_PORTS-1:0] elig;
  logic [N_PORTS-1:0] pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic [N_PORTS-1:0] gnt;
  logic               fire;
  logic               has_credit;

  assign elig       = bus.req & bus.head;
  assign has_credit = (credits_q != '0);
  assign fire       = |gnt;

  rr_pick #(.N(N_PORTS), .PW(PW)) u_pick (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  // Grant selection and next state; grants are forced low during reset
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt     = '0;
    unique case (state_q)
      IDLE: begin
        if (has_credit && (|elig)) begin
          gnt   = pick_gnt;
          ptr_d = pick_idx;
          if (!bus.tail[pick_idx]) begin
            state_d = LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      LOCKED: begin
        if (bus.req[owner_q] && has_credit) begin
          for (int i = 0; i < N_PORTS; i++) begin
            gnt[i] = (owner_q == PW'(i));
          end
          if (bus.tail[owner_q]) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rst) gnt = '0;
  end

  // Credit bookkeeping; a return while full with no simultaneous fire
  // means the downstream buffer claims more slots than it has
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (fire && !bus.credit_in) begin
      credits_d = credits_q - CW'(1);
    end else if (bus.credit_in && !fire) begin
      if (credits_q == FULL) err_d = 1'b1;
      else                   credits_d = credits_q + CW'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= PW'(N_PORTS - 1);
      credits_q <= FULL;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.fire    = fire;
  assign bus.locked  = (state_q == LOCKED);
  assign bus.credits = credits_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_output_port_allocator.sv
// Scoreboard bench for output_port_allocator: directed scenarios followed
// by random traffic, checked against a packet-level reference model.
module tb_output_port_allocator;

  localparam int N  = 5;
  localparam int CR = 4;
  localparam int CW = 3;

  typedef struct {
    logic [N-1:0]  gnt;
    logic          fire;
    logic          locked;
    logic [CW-1:0] credits;
    logic          err;
  } exp_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   compared;
  int   mismatched;

  // Reference model state: current packet owner (-1 when none), last
  // winner, credit count and sticky error
  int   mOwner;
  int   mLast;
  int   mCredits;
  bit   mErr;

  output_port_allocator_if #(.N_PORTS(N), .CW(CW)) bus ();

  output_port_allocator #(.N_PORTS(N), .CREDITS(CR), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOwner   = -1;
    mLast    = N - 1;
    mCredits = CR;
    mErr     = 1'b0;
  endtask

  // Drive one cycle of inputs, predict that cycle's outputs, advance model
  task automatic applyStimulus(input logic r, input logic [N-1:0] rq,
                               input logic [N-1:0] hd, input logic [N-1:0] tl,
                               input logic ci);
    exp_t e;
    int   win;
    bit   found;
    @(posedge clk);
    #1;
    rst           = r;
    bus.req       = rq;
    bus.head      = hd;
    bus.tail      = tl;
    bus.credit_in = ci;
    win   = -1;
    found = 1'b0;
    if (r && mCredits > 0) begin
      if (mOwner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (mLast + k) % N;
          if (!found && rq[p] && hd[p]) begin
            win   = p;
            found = 1'b1;
          end
        end
      end else if (rq[mOwner]) begin
        win = mOwner;
      end
    end
    e.gnt     = (win >= 0) ? N'(1 << win) : '0;
    e.fire    = (win >= 0);
    e.locked  = (mOwner >= 0);
    e.credits = CW'(mCredits);
    e.err     = mErr;
    expQ.push_back(e);
    if (!r) begin
      modelReset();
    end else begin
      if (win >= 0) begin
        if (mOwner < 0) begin
          mLast = win;
          if (!tl[win]) mOwner = win;
        end else if (tl[win]) begin
          mOwner = -1;
        end
      end
      if (win >= 0 && !ci) mCredits = mCredits - 1;
      else if (ci && win < 0) begin
        if (mCredits == CR) mErr = 1'b1;
        else mCredits = mCredits + 1;
      end
    end
  endtask

  // Monitor: every cycle with a prediction, compare the DUT mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("gnt",     32'(bus.gnt),     32'(e.gnt));
        checkOutput("fire",    32'(bus.fire),    32'(e.fire));
        checkOutput("locked",  32'(bus.locked),  32'(e.locked));
        checkOutput("credits", 32'(bus.credits), 32'(e.credits));
        checkOutput("err",     32'(bus.err),     32'(e.err));
      end
    end
  end

  // Safety net against a hung run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus
  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b0;
    bus.req       = '0;
    bus.head      = '0;
    bus.tail      = '0;
    bus.credit_in = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();

    // Round-robin over all ports with single-flit packets and full credit return
    repeat (6) applyStimulus(1'b1, 5'b11111, 5'b11111, 5'b11111, 1'b1);

    // Port 2 three-flit packet with ports 0 and 4 waiting
    applyStimulus(1'b1, 5'b10101, 5'b10101, 5'b00000, 1'b1);
    applyStimulus(1'b1, 5'b10101, 5'b10001, 5'b00000, 1'b1);
    applyStimulus(1'b1, 5'b10101, 5'b10001, 5'b00100, 1'b1);
    applyStimulus(1'b1, 5'b10001, 5'b10001, 5'b10001, 1'b1);
    applyStimulus(1'b1, 5'b00001, 5'b00001, 5'b00001, 1'b1);

    // Credit exhaustion on port 1, then one returned credit
    repeat (6) applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b00010, 1'b0);
    applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b00010, 1'b1);
    applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b00010, 1'b0);
    applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b00010, 1'b0);

    // Simultaneous fire and credit at 2, then overflow at full
    repeat (2) applyStimulus(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    applyStimulus(1'b1, 5'b00010, 5'b00010, 5'b00010, 1'b1);
    repeat (3) applyStimulus(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b1);
    repeat (2) applyStimulus(1'b1, 5'b00000, 5'b00000, 5'b00000, 1'b0);

    // Reset in the middle of a port 3 packet
    applyStimulus(1'b1, 5'b01000, 5'b01000, 5'b00000, 1'b0);
    applyStimulus(1'b1, 5'b01000, 5'b00000, 5'b00000, 1'b0);
    applyStimulus(1'b0, 5'b01000, 5'b00000, 5'b00000, 1'b0);
    applyStimulus(1'b1, 5'b01000, 5'b00000, 5'b00000, 1'b0);
    applyStimulus(1'b1, 5'b01001, 5'b00001, 5'b01001, 1'b0);

    // Owner port 1 bubbles for three cycles while port 0 waits with a head
    applyStimulus(1'b1, 5'b00011, 5'b00011, 5'b00000, 1'b1);
    repeat (3) applyStimulus(1'b1, 5'b00001, 5'b00001, 5'b00000, 1'b1);
    applyStimulus(1'b1, 5'b00011, 5'b00001, 5'b00000, 1'b1);
    applyStimulus(1'b1, 5'b00011, 5'b00001, 5'b00010, 1'b1);
    applyStimulus(1'b1, 5'b00001, 5'b00001, 5'b00001, 1'b1);

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      applyStimulus(($urandom_range(63) != 0), N'($urandom), N'($urandom),
                    N'($urandom), ($urandom_range(2) == 0));
    end

    // Let the monitor consume the final prediction
    repeat (2) @(negedge clk);
    checkOutput("drain", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
